score_tracker: RTL

- Game-score bookkeeping stage that feeds the 7-segment display driver: produces the 4-bit `score` and `high_score` nibbles that the driver renders.
- Consumes asynchronous event levels from the game logic (pipe passed, collision, start button) and synchronises them into the `segclk` domain.
- Runs the game-phase state machine and maintains the session high score.

---
 rtl/score_tracker.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/score_tracker.sv
// -----------------------------------------------------------------------------
// score_tracker
//
// Game-score bookkeeping stage ahead of the 7-segment display driver. It
// synchronises the asynchronous game-event levels into the segclk domain,
// turns each rising edge into a single-cycle event, runs the
// IDLE / PLAY / OVER game-phase machine and keeps the session high score.
//
// Ports:
//   segclk      in   clock, shared with the display driver
//   clr         in   asynchronous active-high reset
//   pipe_passed in   async level, each rising edge = one pipe cleared
//   collision   in   async level, rising edge = bird hit something
//   start_btn   in   async raw push-button, active-high
//   score       out  [3:0] current score, saturates at SCORE_MAX
//   high_score  out  [3:0] best score since clr
//   game_active out  high while in PLAY
//   new_record  out  high while in OVER if the last game set a new best
//
// Build option:
//   DEBOUNCE_EN  when defined, the synchronised start_btn is debounced
//                (DEBOUNCE_CYCLES identical samples) before edge detection.
//
// Every output comes straight from a flop, so the display driver can sample
// score/high_score on any segclk cycle.
// -----------------------------------------------------------------------------
module score_tracker #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int OVER_HOLD       = 16,
    parameter int SCORE_MAX       = 15
) (
    input  logic       segclk,
    input  logic       clr,
    input  logic       pipe_passed,
    input  logic       collision,
    input  logic       start_btn,
    output logic [3:0] score,
    output logic [3:0] high_score,
    output logic       game_active,
    output logic       new_record
);

    // Synchroniser depth never drops below two flops.
    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int HOLD_W = (OVER_HOLD > 2) ? $clog2(OVER_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(OVER_HOLD - 1);
    localparam logic [3:0]        SCORE_TOP = 4'(SCORE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [SYNC_N-1:0] pass_sync_r;
    logic [SYNC_N-1:0] hit_sync_r;
    logic [SYNC_N-1:0] start_sync_r;
    logic              pass_prev_r;
    logic              hit_prev_r;
    logic              start_prev_r;
    logic              start_lvl_s;
    logic              pass_ev_s;
    logic              hit_ev_s;
    logic              start_ev_s;

    // Multi-flop synchronisers; bit 0 takes the raw level, MSB is the safe copy.
    always_ff @(posedge segclk or posedge clr) begin
        if (clr) begin
            pass_sync_r  <= {SYNC_N{1'b0}};
            hit_sync_r   <= {SYNC_N{1'b0}};
            start_sync_r <= {SYNC_N{1'b0}};
        end else begin
            pass_sync_r  <= {pass_sync_r[SYNC_N-2:0], pipe_passed};
            hit_sync_r   <= {hit_sync_r[SYNC_N-2:0], collision};
            start_sync_r <= {start_sync_r[SYNC_N-2:0], start_btn};
        end
    end

`ifdef DEBOUNCE_EN
    localparam int DB_CYC = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
    localparam int DB_W   = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYC - 1);

    logic [DB_W-1:0] db_cnt_r;
    logic            db_level_r;

    // Debounce: the accepted level flips only after DB_CYC consecutive
    // samples that disagree with it; any agreeing sample restarts the count.
    always_ff @(posedge segclk or posedge clr) begin
        if (clr) begin
            db_cnt_r   <= {DB_W{1'b0}};
            db_level_r <= 1'b0;
        end else if (start_sync_r[SYNC_N-1] != db_level_r) begin
            if (db_cnt_r == DB_LAST) begin
                db_cnt_r   <= {DB_W{1'b0}};
                db_level_r <= start_sync_r[SYNC_N-1];
            end else begin
                db_cnt_r   <= db_cnt_r + {{(DB_W-1){1'b0}}, 1'b1};
                db_level_r <= db_level_r;
            end
        end else begin
            db_cnt_r   <= {DB_W{1'b0}};
            db_level_r <= db_level_r;
        end
    end

    assign start_lvl_s = db_level_r;
`else
    assign start_lvl_s = start_sync_r[SYNC_N-1];
`endif

    // Previous-cycle copies for rising-edge detection.
    always_ff @(posedge segclk or posedge clr) begin
        if (clr) begin
            pass_prev_r  <= 1'b0;
            hit_prev_r   <= 1'b0;
            start_prev_r <= 1'b0;
        end else begin
            pass_prev_r  <= pass_sync_r[SYNC_N-1];
            hit_prev_r   <= hit_sync_r[SYNC_N-1];
            start_prev_r <= start_lvl_s;
        end
    end

    assign pass_ev_s  = pass_sync_r[SYNC_N-1] & ~pass_prev_r;
    assign hit_ev_s   = hit_sync_r[SYNC_N-1] & ~hit_prev_r;
    assign start_ev_s = start_lvl_s & ~start_prev_r;

    // ------------------------------------------------------------------
    // Game-phase state machine
    // ------------------------------------------------------------------
    state_t            state_r;
    state_t            next_state_s;
    logic [HOLD_W-1:0] hold_r;
    logic [HOLD_W-1:0] hold_nx_s;
    logic [3:0]        score_r;
    logic [3:0]        score_nx_s;
    logic [3:0]        high_r;
    logic [3:0]        high_nx_s;
    logic              record_r;
    logic              record_nx_s;
    logic              active_r;
    logic              active_nx_s;

    // State register.
    always_ff @(posedge segclk or posedge clr) begin
        if (clr) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; a start in OVER only counts once the hold expired.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ev_s) begin
                    next_state_s = ST_PLAY;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (hit_ev_s) begin
                    next_state_s = ST_OVER;
                end else begin
                    next_state_s = ST_PLAY;
                end
            end
            ST_OVER: begin
                if (start_ev_s && (hold_r == HOLD_LAST)) begin
                    next_state_s = ST_PLAY;
                end else begin
                    next_state_s = ST_OVER;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Output/datapath decode. Collision beats a same-cycle pass, so the
    // record comparison always sees the pre-increment score.
    always_comb begin
        score_nx_s  = score_r;
        high_nx_s   = high_r;
        record_nx_s = record_r;
        hold_nx_s   = hold_r;
        active_nx_s = (next_state_s == ST_PLAY);
        case (state_r)
            ST_IDLE: begin
                score_nx_s = 4'd0;
                hold_nx_s  = {HOLD_W{1'b0}};
                if (next_state_s == ST_PLAY) begin
                    record_nx_s = 1'b0;
                end else begin
                    record_nx_s = record_r;
                end
            end
            ST_PLAY: begin
                hold_nx_s = {HOLD_W{1'b0}};
                if (next_state_s == ST_OVER) begin
                    if (score_r > high_r) begin
                        high_nx_s   = score_r;
                        record_nx_s = 1'b1;
                    end else begin
                        high_nx_s   = high_r;
                        record_nx_s = 1'b0;
                    end
                end else if (pass_ev_s && (score_r < SCORE_TOP)) begin
                    score_nx_s = score_r + 4'd1;
                end else begin
                    score_nx_s = score_r;
                end
            end
            ST_OVER: begin
                if (next_state_s == ST_PLAY) begin
                    score_nx_s  = 4'd0;
                    record_nx_s = 1'b0;
                    hold_nx_s   = {HOLD_W{1'b0}};
                end else if (hold_r != HOLD_LAST) begin
                    hold_nx_s = hold_r + {{(HOLD_W-1){1'b0}}, 1'b1};
                end else begin
                    hold_nx_s = hold_r;
                end
            end
            default: begin
                score_nx_s  = 4'd0;
                high_nx_s   = 4'd0;
                record_nx_s = 1'b0;
                hold_nx_s   = {HOLD_W{1'b0}};
                active_nx_s = 1'b0;
            end
        endcase
    end

    // Registered datapath and outputs.
    always_ff @(posedge segclk or posedge clr) begin
        if (clr) begin
            score_r  <= 4'd0;
            high_r   <= 4'd0;
            record_r <= 1'b0;
            active_r <= 1'b0;
            hold_r   <= {HOLD_W{1'b0}};
        end else begin
            score_r  <= score_nx_s;
            high_r   <= high_nx_s;
            record_r <= record_nx_s;
            active_r <= active_nx_s;
            hold_r   <= hold_nx_s;
        end
    end

    assign score       = score_r;
    assign high_score  = high_r;
    assign game_active = active_r;
    assign new_record  = record_r;

endmodule
